// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-stage types and constants for the RV32I front end.
package RV32I_definitions;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_STALL,
        S_DROP
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_TGT,
        PC_LATCH
    } pc_sel_t;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_MEM,
        IFID_SKID,
        IFID_KILL
    } ifid_op_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INCR   = 4;

endpackage

// File: rtl/fetch_stall_ctrl_skid_buffer.sv
// One-entry {instr,pc} holding register for a fetch that completed under a stall.
module fetch_skid_buffer #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr <= '0;
            out_pc    <= '0;
            valid     <= 1'b0;
        end else if (clear) begin
            valid     <= 1'b0;
        end else if (load) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
            valid     <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch controller: PC, IF/ID register and IMem valid/ready port with stall/redirect handling.
// Optional perf counters (Stall_cycles, Flush_count) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stall_ctrl
    import RV32I_definitions::*;
#(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = RV32I_definitions::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Pipe_stall,
    input  logic                   EX_Branch_taken,
    input  logic [PC_WIDTH-1:0]    EX_Branch_target,
    output logic                   IMem_req,
    output logic [PC_WIDTH-1:0]    IMem_addr,
    input  logic                   IMem_ready,
    input  logic [INSTR_WIDTH-1:0] IMem_rdata,
    output logic [INSTR_WIDTH-1:0] ID_Instr,
    output logic [PC_WIDTH-1:0]    ID_PC,
    output logic                   ID_Valid,
    output logic                   ID_EX_bubble
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            Stall_cycles,
    output logic [31:0]            Flush_count
`endif
);

    fetch_state_t state, state_nxt;
    pc_sel_t      pc_sel;
    ifid_op_t     ifid_op;
    logic         skid_load, skid_clear, tgt_load;

    logic [PC_WIDTH-1:0]    pc, tgt_q, tgt_in;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic                   skid_valid;

    assign tgt_in       = {EX_Branch_target[PC_WIDTH-1:2], 2'b00};
    assign ID_EX_bubble = Pipe_stall | EX_Branch_taken;
    assign IMem_addr    = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:  state_nxt = S_REQ;
            S_REQ: begin
                if (IMem_ready)
                    state_nxt = (!EX_Branch_taken && Pipe_stall) ? S_STALL : S_REQ;
                else if (EX_Branch_taken)
                    state_nxt = S_DROP;
            end
            S_STALL: if (EX_Branch_taken || !Pipe_stall) state_nxt = S_REQ;
            S_DROP:  if (IMem_ready) state_nxt = S_REQ;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        IMem_req   = 1'b0;
        pc_sel     = PC_HOLD;
        ifid_op    = IFID_HOLD;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        tgt_load   = 1'b0;
        unique case (state)
            S_REQ: begin
                IMem_req = 1'b1;
                if (IMem_ready) begin
                    if (EX_Branch_taken) begin
                        pc_sel  = PC_TGT;
                        ifid_op = IFID_KILL;
                    end else if (Pipe_stall) begin
                        skid_load = 1'b1;
                    end else begin
                        pc_sel  = PC_INC;
                        ifid_op = IFID_MEM;
                    end
                end else if (EX_Branch_taken) begin
                    tgt_load = 1'b1;
                    ifid_op  = IFID_KILL;
                end else if (!Pipe_stall) begin
                    ifid_op = IFID_KILL;
                end
            end
            S_STALL: begin
                if (EX_Branch_taken) begin
                    skid_clear = 1'b1;
                    pc_sel     = PC_TGT;
                    ifid_op    = IFID_KILL;
                end else if (!Pipe_stall) begin
                    skid_clear = 1'b1;
                    pc_sel     = PC_INC;
                    ifid_op    = IFID_SKID;
                end
            end
            // Outstanding request must keep its address; redirect waits for ready.
            S_DROP: begin
                IMem_req = 1'b1;
                if (EX_Branch_taken) begin
                    tgt_load = 1'b1;
                    ifid_op  = IFID_KILL;
                end
                if (IMem_ready) pc_sel = EX_Branch_taken ? PC_TGT : PC_LATCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            tgt_q    <= '0;
            ID_Instr <= NOP_INSTR;
            ID_PC    <= '0;
            ID_Valid <= 1'b0;
        end else begin
            unique case (pc_sel)
                PC_INC:   pc <= pc + PC_WIDTH'(PC_INCR);
                PC_TGT:   pc <= tgt_in;
                PC_LATCH: pc <= tgt_q;
                default:  ;
            endcase
            if (tgt_load) tgt_q <= tgt_in;
            unique case (ifid_op)
                IFID_MEM: begin
                    ID_Instr <= IMem_rdata;
                    ID_PC    <= pc;
                    ID_Valid <= 1'b1;
                end
                IFID_SKID: begin
                    ID_Instr <= skid_instr;
                    ID_PC    <= skid_pc;
                    ID_Valid <= skid_valid;
                end
                IFID_KILL: begin
                    ID_Instr <= NOP_INSTR;
                    ID_Valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fetch_skid_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .in_instr  (IMem_rdata),
        .in_pc     (pc),
        .out_instr (skid_instr),
        .out_pc    (skid_pc),
        .valid     (skid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_cycles <= '0;
            Flush_count  <= '0;
        end else begin
            if (Pipe_stall && !EX_Branch_taken && Stall_cycles != 32'hFFFF_FFFF)
                Stall_cycles <= Stall_cycles + 32'd1;
            if (EX_Branch_taken && Flush_count != 32'hFFFF_FFFF)
                Flush_count <= Flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl; IMem returns 0xA500_0000 | addr.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Pipe_stall = 1'b0;
    logic        EX_Branch_taken = 1'b0;
    logic [31:0] EX_Branch_target = '0;
    logic        IMem_req;
    logic [31:0] IMem_addr;
    logic        IMem_ready = 1'b0;
    logic [31:0] IMem_rdata;
    logic [31:0] ID_Instr;
    logic [31:0] ID_PC;
    logic        ID_Valid;
    logic        ID_EX_bubble;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Stall_cycles;
    logic [31:0] Flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign IMem_rdata = 32'hA500_0000 | IMem_addr;

    fetch_stall_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .Pipe_stall       (Pipe_stall),
        .EX_Branch_taken  (EX_Branch_taken),
        .EX_Branch_target (EX_Branch_target),
        .IMem_req         (IMem_req),
        .IMem_addr        (IMem_addr),
        .IMem_ready       (IMem_ready),
        .IMem_rdata       (IMem_rdata),
        .ID_Instr         (ID_Instr),
        .ID_PC            (ID_PC),
        .ID_Valid         (ID_Valid),
        .ID_EX_bubble     (ID_EX_bubble)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Stall_cycles     (Stall_cycles),
        .Flush_count      (Flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Pipe_stall = 1'b0;
        EX_Branch_taken = 1'b0;
        IMem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req",    {31'b0, IMem_req}, 32'd0);
        chk("rst_addr",   IMem_addr, 32'h0);
        chk("rst_valid",  {31'b0, ID_Valid}, 32'd0);
        chk("rst_instr",  ID_Instr, 32'h13);
        chk("rst_idpc",   ID_PC, 32'h0);
        chk("rst_bubble", {31'b0, ID_EX_bubble}, 32'd0);

        // 1: free-running fetch
        do_reset();
        tick();
        chk("t1_boot_req",   {31'b0, IMem_req}, 32'd1);
        chk("t1_boot_valid", {31'b0, ID_Valid}, 32'd0);
        tick();
        chk("t1_pc0",    ID_PC, 32'h0);
        chk("t1_val0",   {31'b0, ID_Valid}, 32'd1);
        chk("t1_instr0", ID_Instr, 32'hA500_0000);
        tick();
        chk("t1_pc4", ID_PC, 32'h4);
        tick();
        chk("t1_pc8", ID_PC, 32'h8);
        tick();
        chk("t1_pc12",   ID_PC, 32'hC);
        chk("t1_addr16", IMem_addr, 32'h10);

        // 2: load-use stall at PC=8
        do_reset();
        tick(); tick(); tick();
        chk("t2_addr8", IMem_addr, 32'h8);
        Pipe_stall = 1'b1;
        #1;
        chk("t2_bub1", {31'b0, ID_EX_bubble}, 32'd1);
        tick();
        chk("t2_hold_pc1", ID_PC, 32'h4);
        chk("t2_req0",     {31'b0, IMem_req}, 32'd0);
        chk("t2_bub2",     {31'b0, ID_EX_bubble}, 32'd1);
        tick();
        chk("t2_hold_pc2", ID_PC, 32'h4);
        Pipe_stall = 1'b0;
        #1;
        chk("t2_bub_off", {31'b0, ID_EX_bubble}, 32'd0);
        tick();
        chk("t2_skid_pc",    ID_PC, 32'h8);
        chk("t2_skid_instr", ID_Instr, 32'hA500_0008);
        chk("t2_skid_valid", {31'b0, ID_Valid}, 32'd1);
        chk("t2_addr12",     IMem_addr, 32'hC);

        // 3: branch while in S_STALL
        Pipe_stall = 1'b1;
        tick();
        chk("t3_stall_pc", ID_PC, 32'h8);
        EX_Branch_taken = 1'b1;
        EX_Branch_target = 32'h100;
        tick();
        chk("t3_kill_valid", {31'b0, ID_Valid}, 32'd0);
        chk("t3_kill_instr", ID_Instr, 32'h13);
        chk("t3_addr100",    IMem_addr, 32'h100);
        chk("t3_req",        {31'b0, IMem_req}, 32'd1);
        EX_Branch_taken = 1'b0;
        Pipe_stall = 1'b0;
        tick();
        chk("t3_new_pc", ID_PC, 32'h100);
        chk("t3_new_v",  {31'b0, ID_Valid}, 32'd1);

        // 4: branch with memory not ready; unaligned target bits dropped
        IMem_ready = 1'b0;
        EX_Branch_taken = 1'b1;
        EX_Branch_target = 32'h203;
        tick();
        EX_Branch_taken = 1'b0;
        chk("t4_addr_a", IMem_addr, 32'h104);
        chk("t4_valid",  {31'b0, ID_Valid}, 32'd0);
        tick();
        chk("t4_addr_b", IMem_addr, 32'h104);
        chk("t4_req_b",  {31'b0, IMem_req}, 32'd1);
        tick();
        chk("t4_addr_c", IMem_addr, 32'h104);
        IMem_ready = 1'b1;
        tick();
        chk("t4_addr200", IMem_addr, 32'h200);
        chk("t4_discard", {31'b0, ID_Valid}, 32'd0);
        tick();
        chk("t4_pc200",    ID_PC, 32'h200);
        chk("t4_instr200", ID_Instr, 32'hA500_0200);

        // 5: stall and branch together
        Pipe_stall = 1'b1;
        EX_Branch_taken = 1'b1;
        EX_Branch_target = 32'h300;
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("t5_stall_pre", Stall_cycles, 32'd3);
        chk("t5_flush_pre", Flush_count, 32'd2);
`endif
        tick();
        chk("t5_addr300", IMem_addr, 32'h300);
        chk("t5_valid",   {31'b0, ID_Valid}, 32'd0);
        chk("t5_req",     {31'b0, IMem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_stall_post", Stall_cycles, 32'd3);
        chk("t5_flush_post", Flush_count, 32'd3);
`endif
        Pipe_stall = 1'b0;
        EX_Branch_taken = 1'b0;
        tick();
        chk("t5_pc300", ID_PC, 32'h300);

        // 6: async reset inside S_DROP, late ready ignored
        IMem_ready = 1'b0;
        EX_Branch_taken = 1'b1;
        EX_Branch_target = 32'h400;
        tick();
        EX_Branch_taken = 1'b0;
        chk("t6_drop_addr", IMem_addr, 32'h304);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_req",  {31'b0, IMem_req}, 32'd0);
        chk("t6_async_addr", IMem_addr, 32'h0);
        IMem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_boot_addr",  IMem_addr, 32'h0);
        chk("t6_boot_valid", {31'b0, ID_Valid}, 32'd0);
        tick();
        chk("t6_pc0",    ID_PC, 32'h0);
        chk("t6_instr0", ID_Instr, 32'hA500_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
